// File: rtl/hilo_sequencer_if.sv
// Bundle of decode-side, multiplier-side and architectural HI/LO signals
// shared by the HI/LO sequencer and its environment.
interface hilo_sequencer_if;
  logic        issue;
  logic        MULOp;
  logic        ALUOp;
  logic [5:0]  Func;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        stall;
  logic        mul_start;
  logic        mul_signed;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [63:0] mul_prod;
  logic [31:0] hilo_rdata;
  logic [31:0] mul_result;
  logic        mul_result_valid;
  logic [31:0] hi;
  logic [31:0] lo;

  // Environment side: decode stage plus the external multiplier.
  modport master (
    output issue, MULOp, ALUOp, Func, rs_data, rt_data, mul_prod,
    input  stall, mul_start, mul_signed, mul_a, mul_b,
           hilo_rdata, mul_result, mul_result_valid, hi, lo
  );

  // Sequencer side.
  modport slave (
    input  issue, MULOp, ALUOp, Func, rs_data, rt_data, mul_prod,
    output stall, mul_start, mul_signed, mul_a, mul_b,
           hilo_rdata, mul_result, mul_result_valid, hi, lo
  );
endinterface

// File: rtl/hilo_sequencer.sv
// HI/LO sequencer: decodes HI/LO-class instructions, launches a fixed-latency
// external multiply, commits or accumulates into HI/LO, and stalls decode
// only when a dependent instruction meets an operation in flight.
module hilo_sequencer #(
  parameter int unsigned MUL_LAT = 3   // multiplier latency, 1..15
) (
  input  logic       clk,
  input  logic       rst,
  hilo_sequencer_if.slave bus
);

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_MADD  = 6'h00;
  localparam logic [5:0] F_MADDU = 6'h01;
  localparam logic [5:0] F_MUL   = 6'h02;
  localparam logic [5:0] F_MSUB  = 6'h04;
  localparam logic [5:0] F_MSUBU = 6'h05;

  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic [1:0] {K_MULT, K_MADD, K_MSUB, K_MUL} kind_t;

  state_t      state;
  kind_t       kind;
  logic [3:0]  cnt;
  logic [31:0] hi_q, lo_q;
  logic [31:0] mul_a_q, mul_b_q, mul_result_q;
  logic        mul_start_q, mul_signed_q, mul_result_valid_q;

  logic        dec_mfhi, dec_mflo, dec_mthi, dec_mtlo;
  logic        dec_mulcls, dec_signed, dec_hilo;
  kind_t       dec_kind;
  logic        stall, accept;
  logic [63:0] hilo_sum, hilo_diff;

  // Classify the instruction currently in decode.
  always_comb begin
    // NOTE: every signal gets a default first, so no path through the case
    // statements leaves a value held over -- that would infer a latch.
    dec_mfhi   = 1'b0;
    dec_mflo   = 1'b0;
    dec_mthi   = 1'b0;
    dec_mtlo   = 1'b0;
    dec_mulcls = 1'b0;
    dec_signed = 1'b0;
    dec_kind   = K_MULT;
    if (bus.ALUOp) begin
      case (bus.Func)
        F_MFHI:  dec_mfhi = 1'b1;
        F_MTHI:  dec_mthi = 1'b1;
        F_MFLO:  dec_mflo = 1'b1;
        F_MTLO:  dec_mtlo = 1'b1;
        F_MULT:  begin dec_mulcls = 1'b1; dec_signed = 1'b1; dec_kind = K_MULT; end
        F_MULTU: begin dec_mulcls = 1'b1; dec_kind = K_MULT; end
        default: ;
      endcase
    end
    if (bus.MULOp) begin
      case (bus.Func)
        F_MADD:  begin dec_mulcls = 1'b1; dec_signed = 1'b1; dec_kind = K_MADD; end
        F_MADDU: begin dec_mulcls = 1'b1; dec_kind = K_MADD; end
        F_MUL:   begin dec_mulcls = 1'b1; dec_signed = 1'b1; dec_kind = K_MUL;  end
        F_MSUB:  begin dec_mulcls = 1'b1; dec_signed = 1'b1; dec_kind = K_MSUB; end
        F_MSUBU: begin dec_mulcls = 1'b1; dec_kind = K_MSUB; end
        default: ;
      endcase
    end
    dec_hilo = dec_mfhi | dec_mflo | dec_mthi | dec_mtlo | dec_mulcls;
  end

  // A MUL in flight blocks everything; otherwise only HI/LO users wait.
  assign stall  = (state == BUSY) && ((bus.issue && dec_hilo) || (kind == K_MUL));
  assign accept = bus.issue && !stall;

  // 64-bit accumulate; carry/borrow crosses the LO/HI boundary naturally.
  assign hilo_sum  = {hi_q, lo_q} + bus.mul_prod;
  assign hilo_diff = {hi_q, lo_q} - bus.mul_prod;

  // Sequencer FSM: launch, count down, commit; all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= IDLE;
      kind               <= K_MULT;
      cnt                <= 4'd0;
      hi_q               <= 32'd0;
      lo_q               <= 32'd0;
      mul_a_q            <= 32'd0;
      mul_b_q            <= 32'd0;
      mul_signed_q       <= 1'b0;
      mul_start_q        <= 1'b0;
      mul_result_q       <= 32'd0;
      mul_result_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register here
      // samples the pre-edge values and the block order does not matter.
      mul_start_q        <= 1'b0;
      mul_result_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && dec_mulcls) begin
            mul_a_q      <= bus.rs_data;
            mul_b_q      <= bus.rt_data;
            mul_signed_q <= dec_signed;
            mul_start_q  <= 1'b1;
            kind         <= dec_kind;
            cnt          <= 4'(MUL_LAT);
            state        <= BUSY;
          end else if (accept && dec_mthi) begin
            hi_q <= bus.rs_data;
          end else if (accept && dec_mtlo) begin
            lo_q <= bus.rs_data;
          end
        end
        BUSY: begin
          if (cnt == 4'd0) begin
            case (kind)
              K_MULT: {hi_q, lo_q} <= bus.mul_prod;
              K_MADD: {hi_q, lo_q} <= hilo_sum;
              K_MSUB: {hi_q, lo_q} <= hilo_diff;
              K_MUL: begin
                mul_result_q       <= bus.mul_prod[31:0];
                mul_result_valid_q <= 1'b1;
              end
              default: ;
            endcase
            state <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.stall            = stall;
  assign bus.hilo_rdata       = (accept && dec_mfhi) ? hi_q :
                                (accept && dec_mflo) ? lo_q : 32'd0;
  assign bus.mul_start        = mul_start_q;
  assign bus.mul_signed       = mul_signed_q;
  assign bus.mul_a            = mul_a_q;
  assign bus.mul_b            = mul_b_q;
  assign bus.mul_result       = mul_result_q;
  assign bus.mul_result_valid = mul_result_valid_q;
  assign bus.hi               = hi_q;
  assign bus.lo               = lo_q;

endmodule

// File: tb/tb_hilo_sequencer.sv
// Directed bench for hilo_sequencer: a per-cycle vector table plus a
// hand-written reset-abandon sequence, against a fixed-latency multiplier.
module tb_hilo_sequencer;
  localparam int LAT = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hilo_sequencer_if bus ();

  hilo_sequencer #(.MUL_LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // External multiplier: product valid exactly LAT cycles after mul_start,
  // junk at all other times so early or late use is visible.
  logic [63:0] prod_q;
  logic [15:0] vld_sh = 16'd0;
  always @(posedge clk) begin
    vld_sh <= {vld_sh[14:0], bus.mul_start};
    if (bus.mul_start)
      prod_q <= bus.mul_signed
        ? 64'($signed({{32{bus.mul_a[31]}}, bus.mul_a}) * $signed({{32{bus.mul_b[31]}}, bus.mul_b}))
        : ({32'd0, bus.mul_a} * {32'd0, bus.mul_b});
  end
  assign bus.mul_prod = vld_sh[LAT-1] ? prod_q : 64'hDEAD_BEEF_0BAD_F00D;

  typedef enum {I_NONE, I_ADD, I_ODD, I_MFHI, I_MFLO, I_MTHI, I_MTLO,
                I_MULT, I_MULTU, I_MADD, I_MADDU, I_MSUB, I_MSUBU, I_MUL} instr_t;

  typedef struct {
    logic        issue;
    instr_t      op;
    logic [31:0] rs, rt;
    logic        stall;
    logic [31:0] rdata, hi, lo;
    logic        start, sgn, mrv;
    logic [31:0] mres;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iss, input instr_t op, input logic [31:0] rs, input logic [31:0] rt);
    bus.issue   = iss;
    bus.rs_data = rs;
    bus.rt_data = rt;
    bus.ALUOp   = 1'b0;
    bus.MULOp   = 1'b0;
    bus.Func    = 6'h00;
    case (op)
      I_ADD:   begin bus.ALUOp = 1'b1; bus.Func = 6'h20; end
      I_ODD:   begin bus.MULOp = 1'b1; bus.Func = 6'h03; end
      I_MFHI:  begin bus.ALUOp = 1'b1; bus.Func = 6'h10; end
      I_MTHI:  begin bus.ALUOp = 1'b1; bus.Func = 6'h11; end
      I_MFLO:  begin bus.ALUOp = 1'b1; bus.Func = 6'h12; end
      I_MTLO:  begin bus.ALUOp = 1'b1; bus.Func = 6'h13; end
      I_MULT:  begin bus.ALUOp = 1'b1; bus.Func = 6'h18; end
      I_MULTU: begin bus.ALUOp = 1'b1; bus.Func = 6'h19; end
      I_MADD:  begin bus.MULOp = 1'b1; bus.Func = 6'h00; end
      I_MADDU: begin bus.MULOp = 1'b1; bus.Func = 6'h01; end
      I_MUL:   begin bus.MULOp = 1'b1; bus.Func = 6'h02; end
      I_MSUB:  begin bus.MULOp = 1'b1; bus.Func = 6'h04; end
      I_MSUBU: begin bus.MULOp = 1'b1; bus.Func = 6'h05; end
      default: ;
    endcase
  endtask

  task automatic v(input logic iss, input instr_t op, input logic [31:0] rs, input logic [31:0] rt,
                   input logic st, input logic [31:0] rd, input logic [31:0] h, input logic [31:0] l,
                   input logic start, input logic sgn, input logic mrv, input logic [31:0] mres);
    vec_t r;
    r.issue = iss; r.op = op; r.rs = rs; r.rt = rt; r.stall = st; r.rdata = rd;
    r.hi = h; r.lo = l; r.start = start; r.sgn = sgn; r.mrv = mrv; r.mres = mres;
    vecs.push_back(r);
  endtask

  task automatic step(input logic iss, input instr_t op, input logic [31:0] rs, input logic [31:0] rt);
    @(posedge clk);
    #1;
    drive(iss, op, rs, rt);
    @(negedge clk);
  endtask

  localparam logic [31:0] F32 = 32'hFFFF_FFFF;

  initial begin
    rst = 1'b1;
    drive(1'b0, I_NONE, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset stall",      64'(bus.stall), 64'd0);
    check("reset hilo_rdata", 64'(bus.hilo_rdata), 64'd0);
    check("reset mul_start",  64'(bus.mul_start), 64'd0);
    check("reset mul_signed", 64'(bus.mul_signed), 64'd0);
    check("reset mul_a",      64'(bus.mul_a), 64'd0);
    check("reset mul_b",      64'(bus.mul_b), 64'd0);
    check("reset mul_result", 64'(bus.mul_result), 64'd0);
    check("reset mrv",        64'(bus.mul_result_valid), 64'd0);
    check("reset hi",         64'(bus.hi), 64'd0);
    check("reset lo",         64'(bus.lo), 64'd0);
    rst = 1'b0;

    //   iss op       rs          rt          st rdata        hi           lo           start sgn mrv mres
    // MULT -1 x 2, dependent MFHI stalls C1..C4, accepted in C5
    v(1, I_MULT,  F32,        32'd2,      0, 32'd0,        32'd0,       32'd0,       0, 0, 0, 0);
    v(1, I_MFHI,  0,          0,          1, 32'd0,        32'd0,       32'd0,       1, 1, 0, 0);
    v(1, I_MFHI,  0,          0,          1, 32'd0,        32'd0,       32'd0,       0, 0, 0, 0);
    v(1, I_MFHI,  0,          0,          1, 32'd0,        32'd0,       32'd0,       0, 0, 0, 0);
    v(1, I_MFHI,  0,          0,          1, 32'd0,        32'd0,       32'd0,       0, 0, 0, 0);
    v(1, I_MFHI,  0,          0,          0, F32,          F32,         32'hFFFFFFFE, 0, 0, 0, 0);
    // MULTU same operands; non-HI/LO instructions flow under BUSY
    v(1, I_MULTU, F32,        32'd2,      0, 32'd0,        F32,         32'hFFFFFFFE, 0, 0, 0, 0);
    v(0, I_NONE,  0,          0,          0, 32'd0,        F32,         32'hFFFFFFFE, 1, 0, 0, 0);
    v(1, I_ADD,   0,          0,          0, 32'd0,        F32,         32'hFFFFFFFE, 0, 0, 0, 0);
    v(1, I_ODD,   0,          0,          0, 32'd0,        F32,         32'hFFFFFFFE, 0, 0, 0, 0);
    v(0, I_MFHI,  0,          0,          0, 32'd0,        F32,         32'hFFFFFFFE, 0, 0, 0, 0);
    v(1, I_MFLO,  0,          0,          0, 32'hFFFFFFFE, 32'd1,       32'hFFFFFFFE, 0, 0, 0, 0);
    // MADDU carry from LO into HI
    v(1, I_MTHI,  32'd0,      0,          0, 32'd0,        32'd1,       32'hFFFFFFFE, 0, 0, 0, 0);
    v(1, I_MTLO,  F32,        0,          0, 32'd0,        32'd0,       32'hFFFFFFFE, 0, 0, 0, 0);
    v(1, I_MFLO,  0,          0,          0, F32,          32'd0,       F32,         0, 0, 0, 0);
    v(1, I_MADDU, 32'd1,      32'd1,      0, 32'd0,        32'd0,       F32,         0, 0, 0, 0);
    v(0, I_NONE,  0,          0,          0, 32'd0,        32'd0,       F32,         1, 0, 0, 0);
    v(0, I_NONE,  0,          0,          0, 32'd0,        32'd0,       F32,         0, 0, 0, 0);
    v(0, I_NONE,  0,          0,          0, 32'd0,        32'd0,       F32,         0, 0, 0, 0);
    v(0, I_NONE,  0,          0,          0, 32'd0,        32'd0,       F32,         0, 0, 0, 0);
    v(1, I_MFHI,  0,          0,          0, 32'd1,        32'd1,       32'd0,       0, 0, 0, 0);
    // MSUBU borrow across the boundary
    v(1, I_MTHI,  32'd0,      0,          0, 32'd0,        32'd1,       32'd0,       0, 0, 0, 0);
    v(1, I_MTLO,  32'd0,      0,          0, 32'd0,        32'd0,       32'd0,       0, 0, 0, 0);
    v(1, I_MSUBU, 32'd1,      32'd1,      0, 32'd0,        32'd0,       32'd0,       0, 0, 0, 0);
    v(1, I_MFLO,  0,          0,          1, 32'd0,        32'd0,       32'd0,       1, 0, 0, 0);
    v(1, I_MFLO,  0,          0,          1, 32'd0,        32'd0,       32'd0,       0, 0, 0, 0);
    v(1, I_MFLO,  0,          0,          1, 32'd0,        32'd0,       32'd0,       0, 0, 0, 0);
    v(1, I_MFLO,  0,          0,          1, 32'd0,        32'd0,       32'd0,       0, 0, 0, 0);
    v(1, I_MFLO,  0,          0,          0, F32,          F32,         F32,         0, 0, 0, 0);
    // Signed MADD: -1 + (-1 * 3) = -4
    v(1, I_MADD,  F32,        32'd3,      0, 32'd0,        F32,         F32,         0, 0, 0, 0);
    v(0, I_NONE,  0,          0,          0, 32'd0,        F32,         F32,         1, 1, 0, 0);
    v(0, I_NONE,  0,          0,          0, 32'd0,        F32,         F32,         0, 0, 0, 0);
    v(0, I_NONE,  0,          0,          0, 32'd0,        F32,         F32,         0, 0, 0, 0);
    v(0, I_NONE,  0,          0,          0, 32'd0,        F32,         F32,         0, 0, 0, 0);
    v(0, I_NONE,  0,          0,          0, 32'd0,        F32,         32'hFFFFFFFC, 0, 0, 0, 0);
    // Signed MSUB: -4 - (2 * -3) = 2
    v(1, I_MSUB,  32'd2,      32'hFFFFFFFD, 0, 32'd0,      F32,         32'hFFFFFFFC, 0, 0, 0, 0);
    v(1, I_MFLO,  0,          0,          1, 32'd0,        F32,         32'hFFFFFFFC, 1, 1, 0, 0);
    v(1, I_MFLO,  0,          0,          1, 32'd0,        F32,         32'hFFFFFFFC, 0, 0, 0, 0);
    v(1, I_MFLO,  0,          0,          1, 32'd0,        F32,         32'hFFFFFFFC, 0, 0, 0, 0);
    v(1, I_MFLO,  0,          0,          1, 32'd0,        F32,         32'hFFFFFFFC, 0, 0, 0, 0);
    v(1, I_MFLO,  0,          0,          0, 32'd2,        32'd0,       32'd2,       0, 0, 0, 0);
    // MUL 7 x 6 stalls even an ADD; result strobe only in C5
    v(1, I_MUL,   32'd7,      32'd6,      0, 32'd0,        32'd0,       32'd2,       0, 0, 0, 0);
    v(1, I_ADD,   0,          0,          1, 32'd0,        32'd0,       32'd2,       1, 1, 0, 0);
    v(1, I_ADD,   0,          0,          1, 32'd0,        32'd0,       32'd2,       0, 0, 0, 0);
    v(1, I_ADD,   0,          0,          1, 32'd0,        32'd0,       32'd2,       0, 0, 0, 0);
    v(1, I_ADD,   0,          0,          1, 32'd0,        32'd0,       32'd2,       0, 0, 0, 0);
    v(1, I_ADD,   0,          0,          0, 32'd0,        32'd0,       32'd2,       0, 0, 1, 32'd42);
    v(0, I_NONE,  0,          0,          0, 32'd0,        32'd0,       32'd2,       0, 0, 0, 0);
    // MTLO then MFLO next cycle, no stall
    v(1, I_MTLO,  32'h1234,   0,          0, 32'd0,        32'd0,       32'd2,       0, 0, 0, 0);
    v(1, I_MFLO,  0,          0,          0, 32'h1234,     32'd0,       32'h1234,    0, 0, 0, 0);
    // MUL stalls with nothing issued
    v(1, I_MUL,   F32,        F32,        0, 32'd0,        32'd0,       32'h1234,    0, 0, 0, 0);
    v(0, I_NONE,  0,          0,          1, 32'd0,        32'd0,       32'h1234,    1, 1, 0, 0);
    v(0, I_NONE,  0,          0,          1, 32'd0,        32'd0,       32'h1234,    0, 0, 0, 0);
    v(0, I_NONE,  0,          0,          1, 32'd0,        32'd0,       32'h1234,    0, 0, 0, 0);
    v(0, I_NONE,  0,          0,          1, 32'd0,        32'd0,       32'h1234,    0, 0, 0, 0);
    v(0, I_NONE,  0,          0,          0, 32'd0,        32'd0,       32'h1234,    0, 0, 1, 32'd1);

    foreach (vecs[i]) begin
      step(vecs[i].issue, vecs[i].op, vecs[i].rs, vecs[i].rt);
      check($sformatf("row%0d stall", i),      64'(bus.stall),            64'(vecs[i].stall));
      check($sformatf("row%0d hilo_rdata", i), 64'(bus.hilo_rdata),       64'(vecs[i].rdata));
      check($sformatf("row%0d hi", i),         64'(bus.hi),               64'(vecs[i].hi));
      check($sformatf("row%0d lo", i),         64'(bus.lo),               64'(vecs[i].lo));
      check($sformatf("row%0d mul_start", i),  64'(bus.mul_start),        64'(vecs[i].start));
      check($sformatf("row%0d mrv", i),        64'(bus.mul_result_valid), 64'(vecs[i].mrv));
      if (vecs[i].start)
        check($sformatf("row%0d mul_signed", i), 64'(bus.mul_signed), 64'(vecs[i].sgn));
      if (vecs[i].mrv)
        check($sformatf("row%0d mul_result", i), 64'(bus.mul_result), 64'(vecs[i].mres));
    end

    // Reset in C2 of a MULT abandons it with no commit.
    step(1'b1, I_MULT, 32'd5, 32'd5);
    check("rstseq C0 stall", 64'(bus.stall), 64'd0);
    step(1'b0, I_NONE, 32'd0, 32'd0);
    check("rstseq C1 mul_start", 64'(bus.mul_start), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(1'b1, I_MFHI, 32'd0, 32'd0);
    @(negedge clk);
    check("rstseq hi",         64'(bus.hi), 64'd0);
    check("rstseq lo",         64'(bus.lo), 64'd0);
    check("rstseq mul_start",  64'(bus.mul_start), 64'd0);
    check("rstseq stall",      64'(bus.stall), 64'd0);
    check("rstseq mul_result", 64'(bus.mul_result), 64'd0);
    @(posedge clk);
    check("rstseq mul_start in rst", 64'(bus.mul_start), 64'd0);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step(1'b1, I_MFHI, 32'd0, 32'd0);
      check($sformatf("post-rst%0d stall", k), 64'(bus.stall), 64'd0);
      check($sformatf("post-rst%0d mrv", k),   64'(bus.mul_result_valid), 64'd0);
      check($sformatf("post-rst%0d hi", k),    64'(bus.hi), 64'd0);
      check($sformatf("post-rst%0d lo", k),    64'(bus.lo), 64'd0);
    end

    // Sequencer still works after the abandoned operation.
    step(1'b1, I_MULT, 32'd3, 32'd3);
    for (int k = 0; k < LAT + 1; k++) step(1'b0, I_NONE, 32'd0, 32'd0);
    step(1'b0, I_NONE, 32'd0, 32'd0);
    check("after-rst MULT hi", 64'(bus.hi), 64'd0);
    check("after-rst MULT lo", 64'(bus.lo), 64'd9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
